// File: rtl/shared_bus_arbiter3.sv
// Round-robin arbiter/sequencer sharing one registered WIDTH-bit output between three requesters.
// Define ARB_FIXED_PRIO_EN to use fixed priority (req[0] highest) instead of round-robin.
module shared_bus_arbiter3 #(
  parameter int unsigned WIDTH     = 16,
  parameter int unsigned MAX_BURST = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [2:0]       req,
  input  logic [WIDTH-1:0] in0,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  output logic [2:0]       ack,
  output logic [2:0]       gnt,
  output logic [1:0]       sel,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       out_src,
  input  logic             out_ready,
  output logic             busy
);

  localparam int unsigned CntW = $clog2(MAX_BURST + 1);
  localparam logic [CntW-1:0] BurstMax = CntW'(MAX_BURST);

  typedef enum logic {StIdle, StGrant} state_e;

  state_e           state_q;
  logic [2:0]       gnt_q;
  logic [1:0]       sel_q;
  logic [CntW-1:0]  beat_cnt_q;
  logic             out_valid_q;
  logic [WIDTH-1:0] out_data_q;
  logic [1:0]       out_src_q;
`ifndef ARB_FIXED_PRIO_EN
  logic [1:0]       ptr_q;
`endif

  logic             free;
  logic             own_req;
  logic             other_req;
  logic             beat;
  logic [1:0]       pick;
  logic [CntW-1:0]  cnt_inc;
  logic [WIDTH-1:0] sel_data;

  function automatic logic [2:0] dec(input logic [1:0] s);
    return 3'b001 << s;
  endfunction

  function automatic logic [1:0] next_idx(input logic [1:0] s);
    return (s == 2'd2) ? 2'd0 : s + 2'd1;
  endfunction

  // gnt_q is one-hot of the owner, so masking req with it avoids indexing by sel
  assign free      = !out_valid_q || out_ready;
  assign own_req   = |(req & gnt_q);
  assign other_req = |(req & ~gnt_q);
  assign beat      = rst_n && (state_q == StGrant) && own_req && free;
  assign cnt_inc   = beat_cnt_q + CntW'(1);

  always_comb begin
    pick = 2'd0;
`ifdef ARB_FIXED_PRIO_EN
    if (req[0])      pick = 2'd0;
    else if (req[1]) pick = 2'd1;
    else             pick = 2'd2;
`else
    case (ptr_q)
      2'd1:    pick = req[1] ? 2'd1 : (req[2] ? 2'd2 : 2'd0);
      2'd2:    pick = req[2] ? 2'd2 : (req[0] ? 2'd0 : 2'd1);
      default: pick = req[0] ? 2'd0 : (req[1] ? 2'd1 : 2'd2);
    endcase
`endif
  end

  always_comb begin
    sel_data = in0;
    case (sel_q)
      2'd1:    sel_data = in1;
      2'd2:    sel_data = in2;
      default: sel_data = in0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      gnt_q       <= 3'b000;
      sel_q       <= 2'd0;
      beat_cnt_q  <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_src_q   <= 2'd0;
`ifndef ARB_FIXED_PRIO_EN
      ptr_q       <= 2'd0;
`endif
    end else begin
      if (beat) begin
        out_data_q  <= sel_data;
        out_src_q   <= sel_q;
        out_valid_q <= 1'b1;
      end else if (out_valid_q && out_ready) begin
        out_valid_q <= 1'b0;
      end

      case (state_q)
        StIdle: begin
          if (|req) begin
            state_q    <= StGrant;
            gnt_q      <= dec(pick);
            sel_q      <= pick;
            beat_cnt_q <= '0;
          end
        end
        StGrant: begin
          // Release takes priority; a dropped req while stalled still releases
          if (!own_req || (beat && cnt_inc == BurstMax && other_req)) begin
            state_q <= StIdle;
            gnt_q   <= 3'b000;
            sel_q   <= 2'd0;
`ifndef ARB_FIXED_PRIO_EN
            ptr_q   <= next_idx(sel_q);
`endif
          end else if (beat) begin
            beat_cnt_q <= (cnt_inc == BurstMax) ? '0 : cnt_inc;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign ack       = beat ? gnt_q : 3'b000;
  assign gnt       = gnt_q;
  assign sel       = sel_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_src   = out_src_q;
  assign busy      = (state_q == StGrant);

endmodule

// File: tb/tb_shared_bus_arbiter3.sv
// Self-checking bench for shared_bus_arbiter3 against an integer-level behavioural model.
module tb_shared_bus_arbiter3;

  localparam int MAX_BURST = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [2:0]  req;
  logic [15:0] din [3];
  logic [2:0]  ack;
  logic [2:0]  gnt;
  logic [1:0]  sel;
  logic        out_valid;
  logic [15:0] out_data;
  logic [1:0]  out_src;
  logic        out_ready;
  logic        busy;

  int vectors = 0;
  int miscompares = 0;

  // Model state: owner index (-1 when idle), rotation pointer, burst count, output register
  int          m_owner;
  int          m_ptr;
  int          m_cnt;
  logic        m_ov;
  logic [15:0] m_od;
  int          m_os;

  always #5 clk = ~clk;

  shared_bus_arbiter3 #(.WIDTH(16), .MAX_BURST(MAX_BURST)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .in0       (din[0]),
    .in1       (din[1]),
    .in2       (din[2]),
    .ack       (ack),
    .gnt       (gnt),
    .sel       (sel),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_src   (out_src),
    .out_ready (out_ready),
    .busy      (busy)
  );

  function automatic logic [27:0] exp_vec();
    logic [2:0] g;
    logic [2:0] a;
    logic       owned;
    g     = (m_owner < 0) ? 3'b000 : (3'b001 << m_owner);
    owned = (m_owner >= 0) ? req[m_owner] : 1'b0;
    a     = (rst_n && owned && (!m_ov || out_ready)) ? g : 3'b000;
    return {a, g, (m_owner < 0) ? 2'd0 : 2'(m_owner), m_ov, m_od, 2'(m_os), m_owner >= 0};
  endfunction

  task automatic model_update();
    logic b;
    logic found;
    int   j;
    if (!rst_n) begin
      m_owner = -1; m_ptr = 0; m_cnt = 0; m_ov = 1'b0; m_od = '0; m_os = 0;
      return;
    end
    b = (m_owner >= 0) && req[m_owner] && (!m_ov || out_ready);
    if (b) begin
      m_od = din[m_owner];
      m_os = m_owner;
      m_ov = 1'b1;
    end else if (m_ov && out_ready) begin
      m_ov = 1'b0;
    end
    if (m_owner < 0) begin
      found = 1'b0;
      for (int k = 0; k < 3; k++) begin
`ifdef ARB_FIXED_PRIO_EN
        j = k;
`else
        j = (m_ptr + k) % 3;
`endif
        if (!found && req[j]) begin
          found = 1'b1;
          m_owner = j;
          m_cnt = 0;
        end
      end
    end else if (!req[m_owner]) begin
      m_ptr = (m_owner + 1) % 3;
      m_owner = -1;
    end else if (b) begin
      m_cnt++;
      if (m_cnt == MAX_BURST) begin
        if ((req & ~(3'b001 << m_owner)) != 3'b000) begin
          m_ptr = (m_owner + 1) % 3;
          m_owner = -1;
        end else begin
          m_cnt = 0;
        end
      end
    end
  endtask

  task automatic drive(input logic [2:0] r, input logic rdy, input logic rs);
    req = r;
    out_ready = rdy;
    rst_n = rs;
    for (int i = 0; i < 3; i++) din[i] = 16'($urandom);
  endtask

  task automatic advance();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic test_reset();
    for (int c = 0; c < 2; c++) begin
      drive(3'b111, 1'b1, 1'b0);
      @(negedge clk);
      vectors++;
      if ({ack, gnt, sel, out_valid, out_data, out_src, busy} !== exp_vec() ||
          {ack, gnt, out_valid, out_data, sel, busy} !== 25'd0) begin
        miscompares++;
        $display("FAIL reset c%0d: got %h want %h", c,
                 {ack, gnt, sel, out_valid, out_data, out_src, busy}, exp_vec());
      end
      advance();
    end
  endtask

  task automatic test_single();
    for (int c = 0; c < 5; c++) begin
      drive((c < 2) ? 3'b010 : 3'b000, 1'b1, 1'b1);
      din[1] = 16'hBEEF;
      @(negedge clk);
      vectors++;
      if ({ack, gnt, sel, out_valid, out_data, out_src, busy} !== exp_vec()) begin
        miscompares++;
        $display("FAIL single c%0d: got %h want %h", c,
                 {ack, gnt, sel, out_valid, out_data, out_src, busy}, exp_vec());
      end
      if (c == 2) begin
        vectors++;
        if ({out_valid, out_data, out_src} !== {1'b1, 16'hBEEF, 2'b01}) begin
          miscompares++;
          $display("FAIL single_data: got %b/%h/%0d want 1/beef/1", out_valid, out_data, out_src);
        end
      end
      advance();
    end
  endtask

  task automatic test_round_robin();
    drive(3'b000, 1'b1, 1'b0);
    advance();
    for (int c = 0; c < 20; c++) begin
      drive(3'b111, 1'b1, 1'b1);
      din[0] = 16'd1; din[1] = 16'd2; din[2] = 16'd3;
      @(negedge clk);
      vectors++;
      if ({ack, gnt, sel, out_valid, out_data, out_src, busy} !== exp_vec()) begin
        miscompares++;
        $display("FAIL round_robin c%0d: got %h want %h", c,
                 {ack, gnt, sel, out_valid, out_data, out_src, busy}, exp_vec());
      end
      advance();
    end
  endtask

  task automatic test_back_pressure();
    for (int c = 0; c < 14; c++) begin
      drive(3'b100, !(c >= 4 && c < 7), 1'b1);
      @(negedge clk);
      vectors++;
      if ({ack, gnt, sel, out_valid, out_data, out_src, busy} !== exp_vec()) begin
        miscompares++;
        $display("FAIL back_pressure c%0d: got %h want %h", c,
                 {ack, gnt, sel, out_valid, out_data, out_src, busy}, exp_vec());
      end
      advance();
    end
  endtask

  task automatic test_release_burst();
    for (int c = 0; c < 18; c++) begin
      drive((c < 3) ? 3'b001 : (c == 3) ? 3'b000 : 3'b010, 1'b1, 1'b1);
      @(negedge clk);
      vectors++;
      if ({ack, gnt, sel, out_valid, out_data, out_src, busy} !== exp_vec()) begin
        miscompares++;
        $display("FAIL release_burst c%0d: got %h want %h", c,
                 {ack, gnt, sel, out_valid, out_data, out_src, busy}, exp_vec());
      end
      advance();
    end
  endtask

  task automatic test_reset_mid_burst();
    for (int c = 0; c < 9; c++) begin
      drive((c < 5) ? 3'b010 : 3'b111, 1'b1, c != 3);
      @(negedge clk);
      vectors++;
      if ({ack, gnt, sel, out_valid, out_data, out_src, busy} !== exp_vec()) begin
        miscompares++;
        $display("FAIL reset_mid c%0d: got %h want %h", c,
                 {ack, gnt, sel, out_valid, out_data, out_src, busy}, exp_vec());
      end
      advance();
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      drive(3'($urandom), ($urandom_range(0, 3) != 0), ($urandom_range(0, 49) != 0));
      @(negedge clk);
      vectors++;
      if ({ack, gnt, sel, out_valid, out_data, out_src, busy} !== exp_vec()) begin
        miscompares++;
        $display("FAIL random c%0d: got %h want %h", c,
                 {ack, gnt, sel, out_valid, out_data, out_src, busy}, exp_vec());
      end
      advance();
    end
  endtask

  initial begin
    m_owner = -1; m_ptr = 0; m_cnt = 0; m_ov = 1'b0; m_od = '0; m_os = 0;
    drive(3'b111, 1'b1, 1'b0);
    advance();
    test_reset();
    test_single();
    test_round_robin();
    test_back_pressure();
    test_release_burst();
    test_reset_mid_burst();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/shared_bus_arbiter3.md
# shared_bus_arbiter3

- Round-robin arbiter and sequencer for the 16-bit 3-input writeback/data mux: it shares one 16-bit output path between three requesters.
- It generates the mux select (2'b00 = in0, 2'b01 = in1, 2'b10 = in2; 2'b11 never produced) and captures the selected word into a registered output stage.
- It supports bounded bursts and ready/valid back-pressure.
- It sits between the requesting units and the register-file write port.

## Interface
- WIDTH, 16, data width of each input and of out_data.
- MAX_BURST, 4, maximum consecutive beats granted to one requester while another is waiting (≥1).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  reset, synchronous, active-low.
- req  input  3  req[i]: requester i has a valid word on in_i; held until acked.
- in0, in1, in2  input  WIDTH  requester data.
- ack  output  3  one-hot, combinational; ack[i]=1 in the cycle requester i's word is captured.
- gnt  output  3  one-hot registered current owner; 0 in IDLE.
- sel  output  2  mux select of current owner; 2'b00 in IDLE.
- out_valid  output  1  out_data holds an unconsumed word.
- out_data  output  WIDTH  captured word.
- out_src  output  2  select code of the requester that produced out_data.
- out_ready  input  1  consumer accepts out_data when out_valid && out_ready.
- busy  output  1  state == GRANT.

## Operation
- States: IDLE, GRANT.
- Reset (rst_n=0 at a clock edge) sets:
  - state=IDLE, ptr=0, beat_cnt=0.
  - gnt=0, sel=0, out_valid=0, out_data=0, out_src=0.
  - ack=0 combinationally while in reset.
  - Reset mid-burst discards the burst; an unconsumed out_data is dropped.
- IDLE:
  - If req≠0, pick the first requester with req set, searching ptr, ptr+1, ptr+2 mod 3.
  - Next cycle: GRANT, gnt/sel = winner, beat_cnt=0.
  - If req=0, stay in IDLE.
- GRANT:
  - Output slot free: free = !out_valid || out_ready.
  - Beat: req[sel] && free. On a beat:
    - ack[sel]=1.
    - out_data <= selected input, out_src <= sel, out_valid <= 1.
    - beat_cnt increments.
  - No beat and out_valid && out_ready: out_valid <= 0.
- GRANT exits:
  - **Release:** req[sel]=0 → IDLE, ptr=sel+1 mod 3. No beat occurs that cycle.
  - **Burst limit:** a beat makes beat_cnt reach MAX_BURST and another req bit is set → IDLE, ptr=sel+1 mod 3.
  - **Burst limit, no competitor:** beat_cnt resets to 0 and the grant continues.
  - **Back-pressure:** while !free the grant is held, no ack, beat_cnt frozen.
    - req[sel] dropping while stalled still releases.
- req bits for non-owners are ignored until re-arbitration.
- A requester must not drop req without an ack. If it does, this is treated as release; no data is lost on the arbiter side.

## Timing
- req[i] rises in cycle 0 with state IDLE → gnt valid cycle 1, ack[i] cycle 1 (if free), out_valid cycle 2.
- req-to-out_valid latency: 2 cycles.
- Throughput: 1 beat/cycle while owner's req and out_ready stay high.
- Ownership change costs exactly one IDLE bubble cycle with no ack.
- Simultaneous consume and capture in one cycle: out_valid stays 1 and out_data is replaced; no word is lost or duplicated.
- ack is combinational from req, state, out_valid and out_ready. There is no combinational path from in0..in2 to any control output.

## Configuration
- ARB_FIXED_PRIO_EN defined: IDLE picks the lowest-index requesting input (req[0] highest priority) and ptr is unused.
  - Burst-limit exit still occurs when another req is pending.
  - Re-arbitration may re-grant the same requester if it is highest priority.
- Not defined: round-robin as described above.

## Test plan
- **Reset:** hold rst_n=0 two cycles with req=3'b111 → gnt=0, ack=0, out_valid=0, out_data=0, sel=0, busy=0.
- **Single request:** req=3'b010, in1=16'hBEEF, out_ready=1 → gnt=3'b010 cycle 1, ack=3'b010 cycle 1, out_valid=1, out_data=16'hBEEF, out_src=2'b01 cycle 2.
- **Round-robin fairness:**
  - Setup: req=3'b111 held, MAX_BURST=4, in0=1, in1=2, in2=3, out_ready=1.
  - Required output: four beats of 1, bubble, four beats of 2, bubble, four beats of 3, bubble, then 1 again.
  - With ARB_FIXED_PRIO_EN: requester 0 beats resume after each bubble.
- **Back-pressure:** requester 2 streaming, out_ready=0 for 3 cycles → exactly one word captured, ack=0 during the stall, out_data stable. On out_ready=1, one ack per cycle resumes with no lost or duplicated words.
- **Release and burst edge:**
  - Requester 0 drops req after 2 beats → IDLE next cycle, ptr=1.
  - Requester 1 alone for 9 beats → no bubble at beat 4 or 8.
- **Reset mid-burst:** rst_n=0 during beat 3 of requester 1 → next cycle IDLE, out_valid=0, and the arbiter restarts at ptr=0.
